div_sequencer: RTL and testbench

- Controller between the execute-stage M-extension issue logic and the iterative 32-bit divider.
- Accepts div/divu/rem/remu requests over a valid/ready handshake and sequences the divider's select/operand interface.
- Resolves divide-by-zero and signed overflow without starting the divider.
- Returns a tagged result over a second valid/ready handshake and supports pipeline flush.

---
 rtl/div_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_div_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Sequencer between M-extension issue logic and an iterative 32-bit divider.
// Optional DIV_REUSE_EN keeps the last divider result for an identical repeat request.
module div_sequencer #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [2:0]       div_divsel,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic             div_ready,
  input  logic [31:0]      div_res
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_REM  = 3'b011;
  localparam logic [2:0] OP_REMU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic [2:0]         divsel_q, divsel_d;

  logic               accept_s;
  logic               op_legal_s;
  logic               op_signed_s;
  logic               op_rem_s;
  logic               b_zero_s;
  logic               ovf_s;
  logic               hit_s;
  logic [31:0]        hit_res_s;

  assign accept_s    = req_valid & req_ready & ~flush;
  assign op_legal_s  = (req_op == OP_DIV) | (req_op == OP_DIVU) |
                       (req_op == OP_REM) | (req_op == OP_REMU);
  assign op_signed_s = (req_op == OP_DIV) | (req_op == OP_REM);
  assign op_rem_s    = (req_op == OP_REM) | (req_op == OP_REMU);
  assign b_zero_s    = (req_b == 32'h0000_0000);
  assign ovf_s       = op_signed_s & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);

`ifdef DIV_REUSE_EN
  logic               last_vld_q;
  logic [2:0]         last_op_q;
  logic [31:0]        last_a_q;
  logic [31:0]        last_b_q;
  logic [31:0]        last_res_q;
  logic               from_div_q;

  assign hit_s     = last_vld_q & (req_op == last_op_q) & (req_a == last_a_q) & (req_b == last_b_q);
  assign hit_res_s = last_res_q;

  // Reuse entry: only a divider result that was actually handed to the consumer is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld_q <= 1'b0;
      last_op_q  <= OP_NONE;
      last_a_q   <= 32'h0000_0000;
      last_b_q   <= 32'h0000_0000;
      last_res_q <= 32'h0000_0000;
      from_div_q <= 1'b0;
    end else begin
      if (state_q == S_RUN) begin
        from_div_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        from_div_q <= 1'b0;
      end else begin
        from_div_q <= from_div_q;
      end
      if ((state_q == S_DONE) && rsp_ready && !flush && from_div_q) begin
        last_vld_q <= 1'b1;
        last_op_q  <= op_q;
        last_a_q   <= a_q;
        last_b_q   <= b_q;
        last_res_q <= rsp_data_q;
      end
    end
  end
`else
  assign hit_s     = 1'b0;
  assign hit_res_s = 32'h0000_0000;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          tag_d = req_tag;
          if (!op_legal_s) begin
            state_d    = S_DONE;
            rsp_data_d = 32'h0000_0000;
          end else if (b_zero_s) begin
            state_d    = S_DONE;
            rsp_data_d = op_rem_s ? req_a : 32'hFFFF_FFFF;
          end else if (ovf_s) begin
            state_d    = S_DONE;
            rsp_data_d = op_rem_s ? 32'h0000_0000 : 32'h8000_0000;
          end else if (hit_s) begin
            state_d    = S_DONE;
            rsp_data_d = hit_res_s;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (div_ready) begin
          state_d    = S_DONE;
          rsp_data_d = div_res;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        // Flush and handshake both leave DONE; flush takes priority by construction.
        if (flush || rsp_ready) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (div_ready) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    divsel_d    = (state_d == S_RUN) ? op_d : OP_NONE;
    rsp_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      a_q         <= 32'h0000_0000;
      b_q         <= 32'h0000_0000;
      tag_q       <= '0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      divsel_q    <= OP_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      divsel_q    <= divsel_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = tag_q;
  assign busy       = busy_q;
  assign div_divsel = divsel_q;
  assign div_a      = a_q;
  assign div_b      = b_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with a behavioural iterative divider.
module tb_div_sequencer;

  localparam int TAG_W = 5;
  localparam int DLY   = 33;
  localparam int LAT_N = DLY + 2;
  localparam int LIMIT = 100;

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_REM  = 3'b011;
  localparam logic [2:0] OP_REMU = 3'b100;
  localparam logic [2:0] OP_BAD  = 3'b111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = 3'b000;
  logic [31:0]      req_a = 32'h0;
  logic [31:0]      req_b = 32'h0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [2:0]       div_divsel;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_ready = 1'b0;
  logic [31:0]      div_res = 32'h0;

  int checks = 0;
  int errors = 0;
  int nz_cnt = 0;
  int vcnt = 0;
  int rsp_cnt = 0;
  logic [2:0] last_sel = 3'b000;
  logic [7:0] dcnt = 8'd0;

  div_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .div_divsel(div_divsel), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_res(div_res)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 32'hFFFF_FFFF;
    case (sel)
      OP_DIV:  return $signed(a) / $signed(b);
      OP_DIVU: return a / b;
      OP_REM:  return $signed(a) % $signed(b);
      OP_REMU: return a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Divider model: held in reset while divsel is 000, ready pulses for 2 cycles after DLY+1 cycles.
  always @(posedge clk) begin
    if (rst || div_divsel == 3'b000) begin
      dcnt      <= 8'd0;
      div_ready <= 1'b0;
    end else begin
      if (dcnt != 8'd255) dcnt <= dcnt + 8'd1;
      div_ready <= (dcnt == 8'(DLY - 1)) || (dcnt == 8'(DLY));
      div_res   <= ref_div(div_divsel, div_a, div_b);
    end
  end

  always @(negedge clk) begin
    if (div_divsel !== 3'b000) begin
      nz_cnt   = nz_cnt + 1;
      last_sel = div_divsel;
    end
    if (rsp_valid === 1'b1) vcnt = vcnt + 1;
  end

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready && !flush) rsp_cnt = rsp_cnt + 1;
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(output logic v_after);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    v_after = rsp_valid;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got %b required 001", {rsp_valid, busy, req_ready});
    end
    checks++;
    if (rsp_data !== 32'h0 || rsp_tag !== 5'd0 || div_divsel !== 3'b000 || div_a !== 32'h0 || div_b !== 32'h0) begin
      errors++; $display("FAIL reset_data: got data=%h tag=%h sel=%b a=%h b=%h required zeros",
                         rsp_data, rsp_tag, div_divsel, div_a, div_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu;
    int lat; logic va; logic ok;
    nz_cnt = 0;
    do_req(OP_DIVU, 32'd100, 32'd7, 5'd9);
    checks++;
    if (div_divsel !== 3'b010 || div_a !== 32'd100 || div_b !== 32'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL divu_run: got sel=%b a=%0d b=%0d busy=%b required 010/100/7/1",
                         div_divsel, div_a, div_b, busy);
    end
    wait_rsp(lat);
    checks++;
    if (lat != LAT_N) begin errors++; $display("FAIL divu_latency: got %0d required %0d", lat, LAT_N); end
    checks++;
    if (rsp_data !== 32'd14 || rsp_tag !== 5'd9) begin
      errors++; $display("FAIL divu_result: got %0d tag %0d required 14 tag 9", rsp_data, rsp_tag);
    end
    checks++;
    if (nz_cnt < DLY || last_sel !== 3'b010 || div_divsel !== 3'b000) begin
      errors++; $display("FAIL divu_divsel: got cycles=%0d sel=%b now=%b required >=%0d/010/000",
                         nz_cnt, last_sel, div_divsel, DLY);
    end
    consume(va);
    wait_idle(ok);
    checks++;
    if (va !== 1'b0 || ok !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL divu_drain: got valid_after=%b idle=%b ready=%b required 0/1/1", va, ok, req_ready);
    end
  endtask

  task automatic test_signed;
    int lat; logic va; logic ok; logic bad;
    logic [31:0] d0; logic [TAG_W-1:0] t0; int c0;
    do_req(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_rsp(lat);
    checks++;
    if (lat != LAT_N || rsp_data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rem_neg: got %h lat %0d required ffffffff lat %0d", rsp_data, lat, LAT_N);
    end
    consume(va);
    wait_idle(ok);
    do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd17);
    wait_rsp(lat);
    checks++;
    if (rsp_data !== 32'hFFFF_FFFD || rsp_tag !== 5'd17) begin
      errors++; $display("FAIL div_neg: got %h tag %0d required fffffffd tag 17", rsp_data, rsp_tag);
    end
    d0 = rsp_data; t0 = rsp_tag; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0 || req_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL backpressure_hold: got unstable=%b required 0", bad); end
    c0 = rsp_cnt;
    consume(va);
    repeat (5) @(negedge clk);
    checks++;
    if (rsp_cnt - c0 != 1 || va !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: got %0d responses required 1", rsp_cnt - c0);
    end
    wait_idle(ok);
  endtask

  task automatic test_bypass;
    logic [2:0]  ops [6] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_BAD, OP_DIVU};
    logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd40, 32'd7};
    logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF};
    int lat; logic va; logic ok;
    for (int i = 0; i < 6; i++) begin
      nz_cnt = 0;
      do_req(ops[i], as[i], bs[i], 5'(i + 20));
      wait_rsp(lat);
      checks++;
      if (lat != 1 || rsp_data !== exp[i] || rsp_tag !== 5'(i + 20)) begin
        errors++; $display("FAIL bypass_%0d: got %h lat %0d tag %0d required %h lat 1 tag %0d",
                           i, rsp_data, lat, rsp_tag, exp[i], i + 20);
      end
      consume(va);
      wait_idle(ok);
      checks++;
      if (nz_cnt != 0 || ok !== 1'b1) begin
        errors++; $display("FAIL bypass_divsel_%0d: got %0d active cycles idle=%b required 0/1", i, nz_cnt, ok);
      end
    end
  endtask

  task automatic test_flush;
    int lat; logic va; logic ok;
    nz_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = OP_DIVU; req_a = 32'd50; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || nz_cnt != 0) begin
      errors++; $display("FAIL flush_idle: got busy=%b ready=%b active=%0d required 0/1/0", busy, req_ready, nz_cnt);
    end
    vcnt = 0;
    do_req(OP_DIVU, 32'd1000, 32'd10, 5'd11);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (div_divsel !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_run: got sel=%b valid=%b busy=%b required 000/0/1", div_divsel, rsp_valid, busy);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (vcnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_norsp: got %0d valid cycles busy=%b required 0/0", vcnt, busy);
    end
    do_req(OP_DIVU, 32'd9, 32'd3, 5'd4);
    wait_rsp(lat);
    checks++;
    if (lat != LAT_N || rsp_data !== 32'd3 || rsp_tag !== 5'd4) begin
      errors++; $display("FAIL flush_next: got %0d lat %0d tag %0d required 3 lat %0d tag 4", rsp_data, lat, rsp_tag, LAT_N);
    end
    consume(va);
    wait_idle(ok);
  endtask

  task automatic test_reuse;
    int lat; logic va; logic ok;
    do_req(OP_DIVU, 32'd100, 32'd7, 5'd2);
    wait_rsp(lat);
    checks++;
    if (lat != LAT_N || rsp_data !== 32'd14) begin
      errors++; $display("FAIL reuse_first: got %0d lat %0d required 14 lat %0d", rsp_data, lat, LAT_N);
    end
    consume(va);
    wait_idle(ok);
    nz_cnt = 0;
    do_req(OP_DIVU, 32'd100, 32'd7, 5'd6);
    wait_rsp(lat);
    checks++;
    if (rsp_data !== 32'd14 || rsp_tag !== 5'd6) begin
      errors++; $display("FAIL reuse_data: got %0d tag %0d required 14 tag 6", rsp_data, rsp_tag);
    end
`ifdef DIV_REUSE_EN
    checks++;
    if (lat != 1 || nz_cnt != 0) begin
      errors++; $display("FAIL reuse_hit: got lat %0d active %0d required 1/0", lat, nz_cnt);
    end
`else
    checks++;
    if (lat != LAT_N || nz_cnt < DLY) begin
      errors++; $display("FAIL reuse_off: got lat %0d active %0d required %0d/>=%0d", lat, nz_cnt, LAT_N, DLY);
    end
`endif
    consume(va);
    wait_idle(ok);
  endtask

  task automatic test_rst_midrun;
    do_req(OP_REMU, 32'd77, 32'd8, 5'd13);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || div_divsel !== 3'b000 || rsp_valid !== 1'b0 || div_a !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_midrun: got busy=%b sel=%b valid=%b a=%h ready=%b required 0/000/0/0/1",
                         busy, div_divsel, rsp_valid, div_a, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_bypass();
    test_flush();
    test_reuse();
    test_rst_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
